// File: rtl/change_capture_fifo.sv
// change_capture_fifo
//
// Consumer end of the change-detect interface. Every single-cycle update
// strobe stores the 48-bit change word (optionally tagged with a 16-bit
// cycle timestamp) as one FIFO entry. The host drains the head entry as a
// sequence of 16-bit words through a first-word-fall-through read port.
//
// Optional feature macro: CHANGE_CAPTURE_TIMESTAMP_EN
//   defined   : entries are {ts[15:0], q[47:0]}, read as 4 words
//               (ts, q[47:32], q[31:16], q[15:0]).
//   undefined : no timestamp counter or storage, entries are q[47:0],
//               read as 3 words (q[47:32], q[31:16], q[15:0]).
//
// Parameters
//   DEPTH          number of entries (power of 2, >= 2)
//   AW             log2(DEPTH)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   q_in[47:0]     change word, valid with update_in
//   update_in      one-cycle strobe: capture q_in as a new entry
//   rd_en          pop one 16-bit word of the head entry
//   clear_overflow clear overflow flag and drop counter
//   dout[15:0]     current head word, 0 when empty
//   empty          no entry stored
//   full           DEPTH entries stored
//   count[AW:0]    number of stored entries
//   overflow       sticky: an update was dropped
//   drop_count     dropped updates, saturating at 0xFFFF
module change_capture_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [47:0]   q_in,
   input  logic          update_in,
   input  logic          rd_en,
   input  logic          clear_overflow,
   output logic [15:0]   dout,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic [15:0]   drop_count
);

`ifdef CHANGE_CAPTURE_TIMESTAMP_EN
   localparam int EW = 64;
   localparam int NW = 4;
`else
   localparam int EW = 48;
   localparam int NW = 3;
`endif

   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [1:0]    LAST_IDX = 2'(NW-1);

   // Entry storage holds data only; validity is tracked by the pointers
   // and count, so the array itself is never reset.
   logic [EW-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [1:0]    word_idx;
   logic [AW:0]   cnt;
   logic [EW-1:0] entry;
   logic [EW-1:0] head;
   logic          pop;
   logic          last_pop;
   logic          wr_acc;
   logic          drop;

`ifdef CHANGE_CAPTURE_TIMESTAMP_EN
   logic [15:0]   ts;

   // Free-running cycle counter; reads 0 in the first cycle after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts <= 16'd0;
      end else begin
         ts <= ts + 16'd1;
      end
   end

   assign entry = {ts, q_in};
`else
   assign entry = q_in;
`endif

   assign empty = (cnt == '0);
   assign full  = (cnt == CNT_FULL);
   assign count = cnt;

   assign pop      = rd_en && !empty;
   assign last_pop = pop && (word_idx == LAST_IDX);
   // A last-word pop frees the head slot in the same cycle, so a write
   // arriving at full is still accepted (it lands in the slot being freed).
   assign wr_acc   = update_in && (!full || last_pop);
   assign drop     = update_in && full && !last_pop;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= entry;
      end
   end

   assign head = mem[rd_ptr];

   // Word 0 is always the most significant 16 bits of the entry, so the
   // same slices serve both entry widths; the last word is head[15:0].
   always_comb begin
      dout = 16'd0;
      if (!empty) begin
         case (word_idx)
            2'd0:    dout = head[EW-1  -: 16];
            2'd1:    dout = head[EW-17 -: 16];
            2'd2:    dout = head[EW-33 -: 16];
            default: dout = head[15:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         word_idx <= 2'd0;
         cnt      <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            if (last_pop) begin
               word_idx <= 2'd0;
               rd_ptr   <= rd_ptr + PTR_ONE;
            end else begin
               word_idx <= word_idx + 2'd1;
            end
         end
         if (wr_acc && !last_pop) begin
            cnt <= cnt + CNT_ONE;
         end else if (last_pop && !wr_acc) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

   // A drop in the same cycle as clear_overflow wins: the flag stays set
   // and the counter restarts at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_count <= 16'd0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clear_overflow) begin
            drop_count <= 16'd1;
         end else if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
         end
      end else if (clear_overflow) begin
         overflow   <= 1'b0;
         drop_count <= 16'd0;
      end
   end

endmodule

// File: tb/tb_change_capture_fifo.sv
module tb_change_capture_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
`ifdef CHANGE_CAPTURE_TIMESTAMP_EN
   localparam int NW = 4;
`else
   localparam int NW = 3;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [47:0]   q_in = '0;
   logic          update_in = 1'b0;
   logic          rd_en = 1'b0;
   logic          clear_overflow = 1'b0;
   logic [15:0]   dout;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          overflow;
   logic [15:0]   drop_count;

   int n_vec = 0;
   int n_err = 0;

   change_capture_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .q_in(q_in), .update_in(update_in),
      .rd_en(rd_en), .clear_overflow(clear_overflow), .dout(dout),
      .empty(empty), .full(full), .count(count), .overflow(overflow),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of {ts, q} entries plus the read position
   // inside the head entry, a cycle timestamp and the drop bookkeeping.
   logic [63:0] mq[$];
   int          m_widx;
   logic [15:0] m_ts;
   logic        m_ov;
   int          m_drops;

   function automatic logic [15:0] word_of(input logic [63:0] e, input int idx);
      logic [15:0] w [4];
`ifdef CHANGE_CAPTURE_TIMESTAMP_EN
      w[0] = e[63:48]; w[1] = e[47:32]; w[2] = e[31:16]; w[3] = e[15:0];
`else
      w[0] = e[47:32]; w[1] = e[31:16]; w[2] = e[15:0];  w[3] = 16'd0;
`endif
      return w[idx];
   endfunction

   function automatic logic [15:0] exp_dout();
      if (mq.size() == 0) return 16'd0;
      return word_of(mq[0], m_widx);
   endfunction

   function automatic logic [AW:0] exp_count();
      return (AW+1)'(mq.size());
   endfunction

   task automatic model_reset();
      mq.delete();
      m_widx = 0; m_ts = 16'd0; m_ov = 1'b0; m_drops = 0;
   endtask

   // One clock of the model: a last-word pop frees space first, then the
   // update is stored if there is room, otherwise it is a drop.
   task automatic model_step(input logic upd, input logic [47:0] q,
                             input logic rd, input logic clr);
      bit last;
      bit dropped;
      dropped = 0;
      last = rd && (mq.size() > 0) && (m_widx == NW-1);
      if (rd && mq.size() > 0) begin
         if (last) begin
            void'(mq.pop_front());
            m_widx = 0;
         end else begin
            m_widx++;
         end
      end
      if (upd) begin
         if (mq.size() < DEPTH) mq.push_back({m_ts, q});
         else dropped = 1;
      end
      if (dropped) begin
         m_ov = 1'b1;
         m_drops = clr ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
      end else if (clr) begin
         m_ov = 1'b0;
         m_drops = 0;
      end
      m_ts = m_ts + 16'd1;
   endtask

   // Drive one cycle of inputs (applied just after an edge), advance the
   // model, and return 1 time unit after the next rising edge.
   task automatic cycle(input logic upd, input logic [47:0] q,
                        input logic rd, input logic clr);
      update_in = upd; q_in = q; rd_en = rd; clear_overflow = clr;
      model_step(upd, q, rd, clr);
      @(posedge clk); #1;
      update_in = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0;
   endtask

   task automatic do_reset();
      update_in = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0; q_in = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec += 6;
      if (empty !== 1'b1)      begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
      if (full !== 1'b0)       begin n_err++; $display("FAIL reset_full got %b want 0", full); end
      if (count !== '0)        begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
      if (dout !== 16'd0)      begin n_err++; $display("FAIL reset_dout got %h want 0000", dout); end
      if (overflow !== 1'b0)   begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
      if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", drop_count); end
   endtask

   task automatic test_single_update();
      logic [15:0] ev [4];
`ifdef CHANGE_CAPTURE_TIMESTAMP_EN
      ev[0] = 16'h0010; ev[1] = 16'h1234; ev[2] = 16'h5678; ev[3] = 16'h9ABC;
`else
      ev[0] = 16'h1234; ev[1] = 16'h5678; ev[2] = 16'h9ABC; ev[3] = 16'h0000;
`endif
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, 48'h123456789ABC, 1'b0, 1'b0);
      n_vec += 2;
      if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty got %b want 0", empty); end
      if (count !== 5'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count); end
      for (int w = 0; w < NW; w++) begin
         n_vec++;
         if (dout !== ev[w]) begin n_err++; $display("FAIL single_word%0d got %h want %h", w, dout, ev[w]); end
         cycle(1'b0, '0, 1'b1, 1'b0);
      end
      n_vec += 2;
      if (empty !== 1'b1)  begin n_err++; $display("FAIL single_drained_empty got %b want 1", empty); end
      if (dout !== 16'd0)  begin n_err++; $display("FAIL single_drained_dout got %h want 0000", dout); end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int k = 1; k <= 20; k++) cycle(1'b1, 48'(k), 1'b0, 1'b0);
      n_vec += 4;
      if (full !== 1'b1)         begin n_err++; $display("FAIL fill_full got %b want 1", full); end
      if (count !== 5'd16)       begin n_err++; $display("FAIL fill_count got %0d want 16", count); end
      if (overflow !== 1'b1)     begin n_err++; $display("FAIL fill_overflow got %b want 1", overflow); end
      if (drop_count !== 16'd4)  begin n_err++; $display("FAIL fill_drop got %0d want 4", drop_count); end
      // Drop coinciding with clear: drop wins.
      cycle(1'b1, 48'hDEAD, 1'b0, 1'b1);
      n_vec += 2;
      if (overflow !== 1'b1)     begin n_err++; $display("FAIL clrdrop_overflow got %b want 1", overflow); end
      if (drop_count !== 16'd1)  begin n_err++; $display("FAIL clrdrop_drop got %0d want 1", drop_count); end
      for (int e = 0; e < DEPTH; e++) begin
         for (int w = 0; w < NW; w++) begin
            n_vec++;
            if (dout !== exp_dout()) begin n_err++; $display("FAIL fill_read e%0d w%0d got %h want %h", e, w, dout, exp_dout()); end
            if (w == NW-1) begin
               n_vec++;
               if (dout !== 16'(e+1)) begin n_err++; $display("FAIL fill_order e%0d got %h want %h", e, dout, 16'(e+1)); end
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
         end
      end
      n_vec++;
      if (empty !== 1'b1) begin n_err++; $display("FAIL fill_drained got empty=%b want 1", empty); end
      cycle(1'b0, '0, 1'b0, 1'b1);
      n_vec += 2;
      if (overflow !== 1'b0)    begin n_err++; $display("FAIL clear_overflow got %b want 0", overflow); end
      if (drop_count !== 16'd0) begin n_err++; $display("FAIL clear_drop got %0d want 0", drop_count); end
   endtask

   task automatic test_simul_full();
      do_reset();
      for (int k = 0; k < DEPTH; k++) cycle(1'b1, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
      for (int w = 0; w < NW-1; w++) cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, 48'hAAAABBBBCCCC, 1'b1, 1'b0);
      n_vec += 3;
      if (count !== 5'd16)   begin n_err++; $display("FAIL simul_count got %0d want 16", count); end
      if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_overflow got %b want 0", overflow); end
      if (full !== 1'b1)     begin n_err++; $display("FAIL simul_full got %b want 1", full); end
      for (int e = 0; e < DEPTH; e++) begin
         for (int w = 0; w < NW; w++) begin
            n_vec++;
            if (dout !== exp_dout()) begin n_err++; $display("FAIL simul_read e%0d w%0d got %h want %h", e, w, dout, exp_dout()); end
            if (e == DEPTH-1 && w == NW-1) begin
               n_vec++;
               if (dout !== 16'hCCCC) begin n_err++; $display("FAIL simul_last got %h want cccc", dout); end
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
         end
      end
      n_vec++;
      if (empty !== 1'b1) begin n_err++; $display("FAIL simul_drained got empty=%b want 1", empty); end
   endtask

   task automatic test_empty_and_wrap();
      logic [47:0] q;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         n_vec += 3;
         if (dout !== 16'd0)  begin n_err++; $display("FAIL empty_rd_dout got %h want 0000", dout); end
         if (count !== '0)    begin n_err++; $display("FAIL empty_rd_count got %0d want 0", count); end
         if (empty !== 1'b1)  begin n_err++; $display("FAIL empty_rd_empty got %b want 1", empty); end
      end
      for (int i = 0; i < 40; i++) begin
         q = {16'($urandom), $urandom};
         cycle(1'b1, q, 1'b0, 1'b0);
         for (int w = 0; w < NW; w++) begin
            n_vec++;
            if (dout !== exp_dout()) begin n_err++; $display("FAIL wrap i%0d w%0d got %h want %h", i, w, dout, exp_dout()); end
            cycle(1'b0, '0, 1'b1, 1'b0);
         end
      end
      n_vec++;
      if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_drained got empty=%b want 1", empty); end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      cycle(1'b1, 48'h111122223333, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      n_vec += 4;
      if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty got %b want 1", empty); end
      if (count !== '0)   begin n_err++; $display("FAIL midrst_count got %0d want 0", count); end
      if (dout !== 16'd0) begin n_err++; $display("FAIL midrst_dout got %h want 0000", dout); end
      if (full !== 1'b0)  begin n_err++; $display("FAIL midrst_full got %b want 0", full); end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle(1'b1, 48'hFEDCBA987654, 1'b0, 1'b0);
      for (int w = 0; w < NW; w++) begin
         n_vec++;
         if (dout !== exp_dout()) begin n_err++; $display("FAIL midrst_read w%0d got %h want %h", w, dout, exp_dout()); end
         if (w == NW-3) begin
            n_vec++;
            if (dout !== 16'hFEDC) begin n_err++; $display("FAIL midrst_qhi got %h want fedc", dout); end
         end
         cycle(1'b0, '0, 1'b1, 1'b0);
      end
      n_vec++;
      if (empty !== 1'b1) begin n_err++; $display("FAIL midrst_drained got empty=%b want 1", empty); end
   endtask

   task automatic test_random();
      logic       upd;
      logic       rd;
      logic       clr;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if ((i / 200) % 2 == 0) begin
            upd = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 3) == 0);
         end else begin
            upd = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 3) != 0);
         end
         clr = ($urandom_range(0, 15) == 0);
         cycle(upd, {16'($urandom), $urandom}, rd, clr);
         n_vec += 6;
         if (dout !== exp_dout())          begin n_err++; $display("FAIL rand_dout c%0d got %h want %h", i, dout, exp_dout()); end
         if (count !== exp_count())        begin n_err++; $display("FAIL rand_count c%0d got %0d want %0d", i, count, exp_count()); end
         if (empty !== (mq.size() == 0))   begin n_err++; $display("FAIL rand_empty c%0d got %b", i, empty); end
         if (full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rand_full c%0d got %b", i, full); end
         if (overflow !== m_ov)            begin n_err++; $display("FAIL rand_overflow c%0d got %b want %b", i, overflow, m_ov); end
         if (drop_count !== 16'(m_drops))  begin n_err++; $display("FAIL rand_drop c%0d got %0d want %0d", i, drop_count, m_drops); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_update();
      test_fill_overflow();
      test_simul_full();
      test_empty_and_wrap();
      test_reset_mid_read();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
